// File: rtl/intf_array_pkg.sv
// Shared types and constants for the slot-array driver and its slot writers.
package intf_array_pkg;

  typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;

  typedef struct packed {
    integer index;
    integer value;
  } req_t;

  localparam int unsigned WR_COUNT_W = 16;

endpackage

// File: rtl/write_intf.sv
// One slot of the driven array: a 32-bit value plus its valid flag.
interface WriteIntf;
  integer x;
  logic   valid;

  // Incremented view offered to readers that want x + 1.
  integer x_inc;
  assign x_inc = x + 1;

  modport Driver(output x, output valid);
  modport Monitor(input x, input valid);
  modport MonitorInc(input x_inc, input valid);
endinterface

// File: rtl/intf_slot_writer.sv
// Holds one slot's value and valid flag; loads wdata whenever we is set.
module intf_slot_writer (
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  integer   wdata,
  WriteIntf.Driver slot
);

  integer x_q;
  logic   valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      valid_q <= 1'b0;
    end else if (we) begin
      x_q     <= wdata;
      valid_q <= 1'b1;
    end
  end

  assign slot.x     = x_q;
  assign slot.valid = valid_q;

endmodule

// File: rtl/intf_array_driver.sv
// Sweeps slots LO..HI with i**2 after reset, then commits indexed write requests.
module intf_array_driver
  import intf_array_pkg::*;
#(
  parameter int LO = 4,
  parameter int HI = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  integer                req_index,
  input  integer                req_value,
  output logic                  init_done,
  output logic                  err,
  output logic [WR_COUNT_W-1:0] wr_count,
  WriteIntf.Driver              slots [LO:HI]
);

  if (LO > HI) begin : g_bad_range
    $error("intf_array_driver: LO (%0d) must not exceed HI (%0d)", LO, HI);
  end

  state_t                state_q, state_d;
  integer                ptr_q, ptr_d;
  req_t                  req_q, req_d;
  logic                  ready_q, ready_d;
  logic                  init_done_q, init_done_d;
  logic                  err_q, err_d;
  logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;

  integer wdata;
  integer req_idx;
  logic   in_range;
  logic   we_sel [LO:HI];

  assign req_idx  = req_q.index;
  assign in_range = (req_idx >= LO) && (req_idx <= HI);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_d       = req_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    wr_count_d  = wr_count_q;
    wdata       = req_q.value;
    unique case (state_q)
      INIT: begin
        wdata = ptr_q * ptr_q;
        if (ptr_q == HI) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1;
        end
      end
      IDLE: begin
        if (req_valid && ready_q) begin
          req_d.index = req_index;
          req_d.value = req_value;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (in_range) begin
          wr_count_d = wr_count_q + WR_COUNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    // Registered ready so the request port never feeds an output combinationally.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      ptr_q       <= LO;
      req_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  for (genvar i = LO; i <= HI; ++i) begin : g_slot
    assign we_sel[i] = ((state_q == INIT) && (ptr_q == i)) ||
                       ((state_q == WRITE) && (req_idx == i));

    intf_slot_writer u_slot (
      .clk  (clk),
      .rst  (rst),
      .we   (we_sel[i]),
      .wdata(wdata),
      .slot (slots[i])
    );
  end

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign wr_count  = wr_count_q;

endmodule
